nios2_oci_dct_capture: RTL and testbench
========================================

NIOS2_OCI_DCT_CAPTURE -- requirements
Module: nios2_oci_dct_capture

Interface
REQ-001 Parameter DCT_W, default 30: width of the debug-capture-trace word.
REQ-002 Parameter CNT_W, default 4: width of the DCT count tag.
REQ-003 Parameter DEPTH, default 16: buffer entries; power of two, 2..256; ADDR_W = log2(DEPTH).
REQ-004 Parameter WRAP_MODE, default 0: 0 = stop-when-full, 1 = overwrite-oldest.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset.
REQ-006 clk  in  1  the single clock; all state changes on its rising edge.
REQ-007 reset  in  1  synchronous reset, active-high.
REQ-008 dct_buffer  in  DCT_W  trace word to capture.
REQ-009 dct_count  in  CNT_W  count tag stored with the word.
REQ-010 dct_valid  in  1  capture strobe; one word per cycle when high.
REQ-011 test_ending  in  1  pulse or level; freezes capture.
REQ-012 test_has_ended  in  1  pulse or level; enters drain phase.
REQ-013 rd_ready  in  1  consumer accepts rd_data this cycle.
REQ-014 rd_valid  out  1  buffer not empty.
REQ-015 rd_data  out  CNT_W+DCT_W  {count, word} of oldest entry, show-ahead.
REQ-016 level  out  ADDR_W+1  current entry count, 0..DEPTH.
REQ-017 overflow  out  1  sticky; a capture was dropped or overwrote an entry.
REQ-018 frozen  out  1  high in FROZEN and DONE.
REQ-019 drained  out  1  high in DONE with level == 0.

Function
REQ-020 FSM states ARMED, FROZEN, DONE; reset enters ARMED.
REQ-021 ARMED -> FROZEN when test_ending = 1; ARMED -> DONE when test_has_ended = 1, which takes priority over test_ending in the same cycle.
REQ-022 FROZEN -> DONE when test_has_ended = 1; DONE exits only on reset.
REQ-023 Capture (write) SHALL occur only in ARMED with dct_valid = 1; a dct_valid coinciding with the ARMED->FROZEN/DONE transition cycle SHALL still be captured.
REQ-024 Reads SHALL be accepted in all states: a pop occurs when rd_valid && rd_ready.
REQ-025 rd_valid = (level != 0); rd_data = oldest entry, combinational from storage; rd_data is don't-care when rd_valid = 0.
REQ-026 Write-to-read latency: a word captured in cycle N SHALL appear at rd_data/rd_valid in cycle N+1 if the buffer was empty.
REQ-027 Write and pop in the same cycle, not full: both occur; level unchanged.
REQ-028 Full, WRAP_MODE = 0, write without pop: word dropped, overflow set, contents unchanged.
REQ-029 Full, WRAP_MODE = 1, write without pop: oldest entry discarded (read pointer advances), new word stored, level stays DEPTH, overflow set.
REQ-030 Full, write with pop (either mode): pop oldest, store new, level stays DEPTH, overflow unchanged.
REQ-031 Empty and rd_ready = 1: no pop; pointers and level unchanged.
REQ-032 Pointers are ADDR_W bits and SHALL wrap modulo DEPTH; level is tracked separately, without wrap.
REQ-033 overflow SHALL clear only on reset.
REQ-034 drained = (state == DONE) && (level == 0), registered-state based, same cycle as level reaches 0.

Reset
REQ-035 On reset: state = ARMED, pointers = 0, level = 0, rd_valid = 0, overflow = 0, frozen = 0, drained = 0; storage contents are not reset.
REQ-036 reset asserted mid-operation SHALL override all concurrent writes, pops and transitions in that cycle.

Verification
REQ-037 DEPTH = 4, WRAP_MODE = 0: write 0x1..0x5 with counts 1..5, no reads -> level = 4, overflow = 1; reads return 0x1..0x4 in order.
REQ-038 DEPTH = 4, WRAP_MODE = 1: same stimulus -> level = 4, overflow = 1; reads return 0x2, 0x3, 0x4, 0x5.
REQ-039 Full buffer, simultaneous write 0x9 and pop -> pops the oldest word, level = 4, overflow remains 0; the last read returns 0x9.
REQ-040 Write 3 words, pulse test_ending, drive dct_valid for 5 cycles -> level stays 3, frozen = 1; pulse test_has_ended, drain 3 -> drained = 1 on the cycle level reaches 0.
REQ-041 Single write to an empty buffer in cycle N -> rd_valid = 0 in cycle N, rd_valid = 1 with the correct rd_data in cycle N+1.
REQ-042 Assert reset mid-drain with level = 2 -> next cycle level = 0, rd_valid = 0, frozen = 0, overflow = 0, and the state is ARMED.

Source files
------------

// File: rtl/nios2_oci_dct_capture.sv
// Debug-capture-trace (DCT) capture buffer.
// Trace words are captured into a circular buffer while the block is ARMED.
// Capture freezes when the test starts ending, and the buffer drains through
// a show-ahead read port. When the buffer is full it either drops new words
// or overwrites the oldest, depending on WRAP_MODE.
module nios2_oci_dct_capture #(
    parameter int DCT_W     = 30,
    parameter int CNT_W     = 4,
    parameter int DEPTH     = 16,
    parameter int WRAP_MODE = 0,
    localparam int ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DCT_W-1:0]       dct_buffer,
    input  logic [CNT_W-1:0]       dct_count,
    input  logic                   dct_valid,
    input  logic                   test_ending,
    input  logic                   test_has_ended,
    input  logic                   rd_ready,
    output logic                   rd_valid,
    output logic [CNT_W+DCT_W-1:0] rd_data,
    output logic [ADDR_W:0]        level,
    output logic                   overflow,
    output logic                   frozen,
    output logic                   drained
);

    localparam int              DATA_W   = CNT_W + DCT_W;
    localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LVL_ZERO = (ADDR_W + 1)'(0);
    localparam logic [ADDR_W:0] LVL_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    typedef enum logic [1:0] {
        ST_ARMED  = 2'd0,
        ST_FROZEN = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wptr_q, wptr_d;
    logic [ADDR_W-1:0]   rptr_q, rptr_d;
    logic [ADDR_W:0]     level_q, level_d;
    logic                overflow_q, overflow_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                wr_req_s;
    logic                pop_s;
    logic                full_s;
    logic                store_s;

    // A dct_valid in the same cycle as leaving ARMED still counts: the
    // request is qualified with the current (registered) state only.
    assign wr_req_s = (state_q == ST_ARMED) && dct_valid;
    assign pop_s    = (level_q != LVL_ZERO) && rd_ready;
    assign full_s   = (level_q == FULL_LVL);

    // Next-state, pointer, level and overflow computation.
    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        store_s    = 1'b0;

        case (state_q)
            ST_ARMED: begin
                if (test_has_ended) begin
                    state_d = ST_DONE;
                end else if (test_ending) begin
                    state_d = ST_FROZEN;
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_FROZEN: begin
                if (test_has_ended) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_FROZEN;
                end
            end
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_ARMED;
        endcase

        if (wr_req_s && (!full_s || pop_s)) begin
            // Room available (or being made by a pop): plain store.
            store_s = 1'b1;
            wptr_d  = wptr_q + PTR_ONE;
            if (pop_s) begin
                rptr_d  = rptr_q + PTR_ONE;
                level_d = level_q;
            end else begin
                rptr_d  = rptr_q;
                level_d = level_q + LVL_ONE;
            end
        end else if (wr_req_s && (WRAP_MODE != 0)) begin
            // Full, overwrite oldest: write slot equals read slot, both advance.
            store_s    = 1'b1;
            wptr_d     = wptr_q + PTR_ONE;
            rptr_d     = rptr_q + PTR_ONE;
            overflow_d = 1'b1;
        end else if (wr_req_s) begin
            // Full, stop-when-full: word is dropped.
            overflow_d = 1'b1;
        end else if (pop_s) begin
            rptr_d  = rptr_q + PTR_ONE;
            level_d = level_q - LVL_ONE;
        end else begin
            level_d = level_q;
        end
    end

    // Control state registers with synchronous reset overriding everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_ARMED;
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Buffer storage; contents deliberately not reset.
    always_ff @(posedge clk) begin
        if (store_s && !reset) begin
            mem_q[wptr_q] <= {dct_count, dct_buffer};
        end
    end

    assign rd_valid = (level_q != LVL_ZERO);
    assign rd_data  = mem_q[rptr_q];
    assign level    = level_q;
    assign overflow = overflow_q;
    assign frozen   = (state_q != ST_ARMED);
    assign drained  = (state_q == ST_DONE) && (level_q == LVL_ZERO);

endmodule

// File: tb/tb_nios2_oci_dct_capture.sv
// Bench for nios2_oci_dct_capture: two DEPTH=4 instances (drop / overwrite)
// driven with identical stimulus, checked every cycle against a queue model,
// plus directed scenarios with hand-computed expectations.
module tb_nios2_oci_dct_capture;

    localparam int DEPTH = 4;
    localparam int DW    = 34;

    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        dct_valid;
    logic        test_ending;
    logic        test_has_ended;
    logic        rd_ready;

    logic          rdv  [2];
    logic [DW-1:0] rdd  [2];
    logic [2:0]    lvl  [2];
    logic          ovf  [2];
    logic          frz  [2];
    logic          drn  [2];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model: per instance a queue of entries, a phase and a sticky flag.
    logic [DW-1:0] mq [2][$];
    int            mst [2];
    bit            movf [2];

    always #5 clk = ~clk;

    nios2_oci_dct_capture #(.DCT_W(30), .CNT_W(4), .DEPTH(DEPTH), .WRAP_MODE(0)) u_drop (
        .clk(clk), .reset(reset), .dct_buffer(dct_buffer), .dct_count(dct_count),
        .dct_valid(dct_valid), .test_ending(test_ending), .test_has_ended(test_has_ended),
        .rd_ready(rd_ready), .rd_valid(rdv[0]), .rd_data(rdd[0]), .level(lvl[0]),
        .overflow(ovf[0]), .frozen(frz[0]), .drained(drn[0]));

    nios2_oci_dct_capture #(.DCT_W(30), .CNT_W(4), .DEPTH(DEPTH), .WRAP_MODE(1)) u_wrap (
        .clk(clk), .reset(reset), .dct_buffer(dct_buffer), .dct_count(dct_count),
        .dct_valid(dct_valid), .test_ending(test_ending), .test_has_ended(test_has_ended),
        .rd_ready(rd_ready), .rd_valid(rdv[1]), .rd_data(rdd[1]), .level(lvl[1]),
        .overflow(ovf[1]), .frozen(frz[1]), .drained(drn[1]));

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Model update on each rising edge from the inputs applied for that cycle.
    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (reset) begin
                mq[m].delete();
                mst[m]  = 0;
                movf[m] = 1'b0;
            end else begin
                bit wr, pop;
                wr  = (mst[m] == 0) && dct_valid;
                pop = (mq[m].size() != 0) && rd_ready;
                if (pop) void'(mq[m].pop_front());
                if (wr) begin
                    if (mq[m].size() < DEPTH) begin
                        mq[m].push_back({dct_count, dct_buffer});
                    end else if (m == 1) begin
                        void'(mq[m].pop_front());
                        mq[m].push_back({dct_count, dct_buffer});
                        movf[m] = 1'b1;
                    end else begin
                        movf[m] = 1'b1;
                    end
                end
                if (mst[m] == 0 && test_has_ended)      mst[m] = 2;
                else if (mst[m] == 0 && test_ending)    mst[m] = 1;
                else if (mst[m] == 1 && test_has_ended) mst[m] = 2;
            end
        end
    end

    // Compare every DUT output with the model on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int m = 0; m < 2; m++) begin
                check("rd_valid", 64'(rdv[m]), 64'(mq[m].size() != 0));
                check("level", 64'(lvl[m]), 64'(mq[m].size()));
                check("overflow", 64'(ovf[m]), 64'(movf[m]));
                check("frozen", 64'(frz[m]), 64'(mst[m] != 0));
                check("drained", 64'(drn[m]), 64'((mst[m] == 2) && (mq[m].size() == 0)));
                if (mq[m].size() != 0) check("rd_data", 64'(rdd[m]), 64'(mq[m][0]));
            end
        end
    end

    // Apply one cycle of inputs and return at the following falling edge.
    task automatic cyc(input logic v, input logic [29:0] w, input logic [3:0] c,
                       input logic te, input logic the, input logic rdy, input logic rst);
        dct_valid      = v;
        dct_buffer     = w;
        dct_count      = c;
        test_ending    = te;
        test_has_ended = the;
        rd_ready       = rdy;
        reset          = rst;
        @(negedge clk);
    endtask

    task automatic idle_reset();
        cyc(1'b0, 30'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [DW-1:0] e;
        int rmode;
        reset = 1'b1; dct_valid = 1'b0; dct_buffer = '0; dct_count = '0;
        test_ending = 1'b0; test_has_ended = 1'b0; rd_ready = 1'b0;
        @(negedge clk);
        idle_reset();
        idle_reset();
        chk_en = 1'b1;

        // Reset state, then single write latency and fill past capacity.
        check("rst_level", 64'(lvl[0]), 64'd0);
        check("rst_rd_valid", 64'(rdv[0]), 64'd0);
        check("rst_frozen", 64'(frz[1]), 64'd0);
        for (int i = 1; i <= 5; i++) begin
            cyc(1'b1, 30'(i), 4'(i), 1'b0, 1'b0, 1'b0, 1'b0);
            if (i == 1) begin
                check("lat_rd_valid", 64'(rdv[0]), 64'd1);
                check("lat_rd_data", 64'(rdd[0]), 64'h0_4000_0001);
            end
        end
        check("full_level_drop", 64'(lvl[0]), 64'd4);
        check("full_ovf_drop", 64'(ovf[0]), 64'd1);
        check("full_level_wrap", 64'(lvl[1]), 64'd4);
        check("full_ovf_wrap", 64'(ovf[1]), 64'd1);
        for (int i = 0; i < 4; i++) begin
            e = {4'(i + 1), 30'(i + 1)};
            check("drop_order", 64'(rdd[0]), 64'(e));
            e = {4'(i + 2), 30'(i + 2)};
            check("wrap_order", 64'(rdd[1]), 64'(e));
            cyc(1'b0, 30'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        check("empty_after_reads", 64'(rdv[0]), 64'd0);
        cyc(1'b0, 30'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("empty_pop_level", 64'(lvl[0]), 64'd0);

        // Full buffer: simultaneous write and pop keeps level, no overflow.
        idle_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, 30'h11 + 30'(i), 4'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 30'h9, 4'h9, 1'b0, 1'b0, 1'b1, 1'b0);
        check("wp_level", 64'(lvl[0]), 64'd4);
        check("wp_ovf_drop", 64'(ovf[0]), 64'd0);
        check("wp_ovf_wrap", 64'(ovf[1]), 64'd0);
        check("wp_head", 64'(rdd[0]), 64'h0_4000_0012);
        for (int i = 0; i < 3; i++) cyc(1'b0, 30'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("wp_last", 64'(rdd[0]), 64'h2_4000_0009);
        cyc(1'b0, 30'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Freeze, ignore further captures, then drain in DONE.
        idle_reset();
        for (int i = 0; i < 3; i++) cyc(1'b1, 30'h20 + 30'(i), 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 30'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 30'h30 + 30'(i), 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        check("frz_level", 64'(lvl[0]), 64'd3);
        check("frz_frozen", 64'(frz[0]), 64'd1);
        cyc(1'b0, 30'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("pre_drained", 64'(drn[0]), 64'd0);
            cyc(1'b0, 30'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        check("drained", 64'(drn[0]), 64'd1);
        check("drained_level", 64'(lvl[0]), 64'd0);

        // Reset in the middle of a drain.
        idle_reset();
        for (int i = 0; i < 5; i++) cyc(1'b1, 30'h40 + 30'(i), 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 30'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 30'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 30'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("mid_level", 64'(lvl[0]), 64'd2);
        cyc(1'b1, 30'h55, 4'd5, 1'b1, 1'b1, 1'b1, 1'b1);
        check("mrst_level", 64'(lvl[0]), 64'd0);
        check("mrst_rd_valid", 64'(rdv[0]), 64'd0);
        check("mrst_frozen", 64'(frz[0]), 64'd0);
        check("mrst_ovf", 64'(ovf[0]), 64'd0);
        cyc(1'b1, 30'h56, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0);
        check("mrst_armed", 64'(lvl[0]), 64'd1);

        // Randomized traffic checked against the model.
        rmode = 2;
        for (int n = 0; n < 3000; n++) begin
            if (n % 64 == 0) rmode = $urandom_range(0, 4);
            cyc(1'($urandom_range(0, 1)), 30'($urandom), 4'($urandom),
                1'($urandom_range(0, 119) == 0), 1'($urandom_range(0, 199) == 0),
                1'($urandom_range(0, 3) < rmode), 1'($urandom_range(0, 299) == 0));
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
